// File: rtl/uart_tx_stream.sv
// Byte-stream 8N1/8N2 UART transmitter with a one-entry holding register in
// front of the shifter, so back-to-back frames go out with no idle gap.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_in,
    output logic       ready_in,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nx;
    logic [7:0]    hold_data;
    logic          hold_v, hold_v_nx;
    logic [7:0]    shift, shift_nx;
    logic [CW-1:0] baud_cnt, baud_cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic          tx_nx;
    logic          load;
    logic          take;

    assign take     = valid_in & ~hold_v;
    assign ready_in = ~hold_v;
    assign busy     = (state != IDLE) | hold_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_v    <= 1'b0;
            shift     <= '0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
        end else begin
            state    <= state_nx;
            hold_v   <= hold_v_nx;
            shift    <= shift_nx;
            baud_cnt <= baud_cnt_nx;
            bit_idx  <= bit_idx_nx;
            tx       <= tx_nx;
            if (take)
                hold_data <= data_i;
        end
    end

    always_comb begin
        state_nx    = state;
        shift_nx    = shift;
        baud_cnt_nx = baud_cnt;
        bit_idx_nx  = bit_idx;
        load        = 1'b0;

        case (state)
            IDLE: begin
                if (hold_v)
                    load = 1'b1;
            end
            START: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_nx = '0;
                    bit_idx_nx  = '0;
                    state_nx    = DATA;
                end else begin
                    baud_cnt_nx = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_nx = '0;
                    shift_nx    = {1'b0, shift[7:1]};
                    bit_idx_nx  = bit_idx + 1'b1;
                    if (bit_idx == 3'd7)
                        state_nx = STOP;
                end else begin
                    baud_cnt_nx = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == STOP_LAST) begin
                    baud_cnt_nx = '0;
                    if (hold_v)
                        load = 1'b1;
                    else
                        state_nx = IDLE;
                end else begin
                    baud_cnt_nx = baud_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Loading from IDLE or the last stop cycle both start a fresh frame.
        if (load) begin
            shift_nx    = hold_data;
            baud_cnt_nx = '0;
            state_nx    = START;
        end

        hold_v_nx = hold_v;
        if (load)
            hold_v_nx = 1'b0;
        else if (take)
            hold_v_nx = 1'b1;

        // tx is registered from the next state so it lines up with that state.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: directed steps drive bytes, a serial
// monitor per instance decodes tx and checks against the scoreboard queues.
module tb_uart_tx_stream;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int frames    [2] = '{0, 0};
    int start_cyc [2] = '{0, 0};
    int end_cyc   [2] = '{0, 0};
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .data_i(data_a), .valid_in(valid_a),
        .ready_in(ready_a), .tx(tx_a), .busy(busy_a)
    );

    uart_tx_stream #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .data_i(data_b), .valid_in(valid_b),
        .ready_in(ready_b), .tx(tx_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Main steps sample 2 ns after the edge; monitors sample at 1 ns.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic monitor(input int inst);
        int         pos = -1;
        int         len = (inst == 0) ? 10 * CPB : 11 * CPB;
        int         bi;
        logic [7:0] b  = '0;
        logic [7:0] rx = '0;
        logic       t;
        logic       e;
        forever begin
            @(posedge clk);
            #1;
            t = (inst == 0) ? tx_a : tx_b;
            if (rst) begin
                pos = -1;
            end else begin
                if (pos < 0 && t == 1'b0) begin
                    pos = 0;
                    start_cyc[inst] = cyc;
                    if (inst == 0) begin
                        check("sb_a_has_entry", (q_a.size() == 0), 0);
                        b = (q_a.size() != 0) ? q_a.pop_front() : 8'h00;
                    end else begin
                        check("sb_b_has_entry", (q_b.size() == 0), 0);
                        b = (q_b.size() != 0) ? q_b.pop_front() : 8'h00;
                    end
                end
                if (pos >= 0) begin
                    bi = pos / CPB - 1;
                    if (pos < CPB)
                        e = 1'b0;
                    else if (pos < 9 * CPB)
                        e = b[bi[2:0]];
                    else
                        e = 1'b1;
                    check($sformatf("tx%0d_pos%0d", inst, pos), t, e);
                    if (pos >= CPB && pos < 9 * CPB && (pos % CPB) == CPB / 2)
                        rx[bi[2:0]] = t;
                    pos++;
                    if (pos == len) begin
                        check($sformatf("rx%0d_byte", inst), rx, b);
                        frames[inst]++;
                        end_cyc[inst] = cyc;
                        pos = -1;
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic send(input int inst, input logic [7:0] b, input bit keep, output int hs);
        int n = 0;
        if (inst == 0) begin data_a = b; valid_a = 1'b1; end
        else           begin data_b = b; valid_b = 1'b1; end
        while (((inst == 0) ? ready_a : ready_b) !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check($sformatf("hs%0d_in_budget", inst), (n < 200), 1);
        tick();
        hs = cyc;
        if (inst == 0) begin
            q_a.push_back(b);
            if (!keep) valid_a = 1'b0;
        end else begin
            q_b.push_back(b);
            if (!keep) valid_b = 1'b0;
        end
    endtask

    task automatic wait_frames(input int inst, input int n);
        int cnt = 0;
        while (frames[inst] < n && cnt < 2000) begin
            tick();
            cnt++;
        end
        check($sformatf("frames%0d_reached", inst), frames[inst], n);
    endtask

    initial begin : main
        int hs, hs2, hs3, e1;
        rst = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = '0;    data_b = '0;

        // Reset state before any clock edge
        #1;
        check("rst_tx_a", tx_a, 1);
        check("rst_ready_a", ready_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_tx_b", tx_b, 1);
        check("rst_busy_b", busy_b, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_tx_a", tx_a, 1);

        // Single byte 0xA5
        send(0, 8'hA5, 1'b0, hs);
        check("t2_ready_lo", ready_a, 0);
        check("t2_busy", busy_a, 1);
        check("t2_tx_still_idle", tx_a, 1);
        tick();
        check("t2_ready_hi", ready_a, 1);
        check("t2_tx_start", tx_a, 0);
        check("t2_start_cyc", start_cyc[0], hs + 1);
        wait_frames(0, 1);
        check("t2_frame_len", end_cyc[0] - start_cyc[0] + 1, 40);
        check("t2_busy_in_stop", busy_a, 1);
        tick();
        check("t2_busy_done", busy_a, 0);
        check("t2_tx_idle", tx_a, 1);

        // Back-to-back 0x55 then 0x0F, second offered during DATA
        send(0, 8'h55, 1'b0, hs);
        repeat (12) tick();
        send(0, 8'h0F, 1'b0, hs2);
        check("t3_ready_lo", ready_a, 0);
        wait_frames(0, 2);
        check("t3_ready_held", ready_a, 0);
        e1 = end_cyc[0];
        tick();
        check("t3_ready_rise", ready_a, 1);
        check("t3_tx_start2", tx_a, 0);
        check("t3_no_gap", start_cyc[0], e1 + 1);
        wait_frames(0, 3);
        tick();

        // Backpressure with valid held continuously
        send(0, 8'h11, 1'b1, hs);
        send(0, 8'h22, 1'b1, hs2);
        send(0, 8'h33, 1'b0, hs3);
        check("t4_hs2_after_load", hs2, hs + 2);
        check("t4_hs3_after_frame1", (hs3 > end_cyc[0]), 1);
        check("t4_frames_at_hs3", frames[0], 4);
        wait_frames(0, 6);
        repeat (60) tick();
        check("t4_no_dup", frames[0], 6);
        check("t4_sb_empty", q_a.size(), 0);

        // Reset mid-frame during DATA bit 3 of 0xFF
        send(0, 8'hFF, 1'b0, hs);
        repeat (18) tick();
        check("t5_busy_pre", busy_a, 1);
        #1 rst = 1'b1;
        #1;
        check("t5_async_tx", tx_a, 1);
        check("t5_async_ready", ready_a, 1);
        check("t5_async_busy", busy_a, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("t5_aborted", frames[0], 6);
        send(0, 8'h81, 1'b0, hs);
        tick();
        check("t5_restart_start", start_cyc[0], hs + 1);
        wait_frames(0, 7);
        check("t5_frame_len", end_cyc[0] - start_cyc[0] + 1, 40);

        // Two stop bits with a queued second byte
        check("t6_b_quiet", frames[1], 0);
        send(1, 8'h00, 1'b0, hs);
        repeat (20) tick();
        send(1, 8'hC3, 1'b0, hs2);
        wait_frames(1, 1);
        check("t6_frame_len", end_cyc[1] - start_cyc[1] + 1, 44);
        check("t6_ready_held", ready_b, 0);
        e1 = end_cyc[1];
        tick();
        check("t6_no_gap", start_cyc[1], e1 + 1);
        check("t6_tx_start2", tx_b, 0);
        wait_frames(1, 2);
        tick();
        check("t6_busy_done", busy_b, 0);
        check("t6_sb_empty", q_b.size(), 0);
        check("end_sb_a_empty", q_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
